// File: rtl/spart_driver_if.sv
// SPART register-access handshake: chip select, direction, address, and the
// two status lines the SPART reports back.
interface spart_driver_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
    modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor from br_cfg, then echoes RX bytes to TX.
// Define SPART_DRV_FIFO_EN for a FIFO_DEPTH-entry echo FIFO instead of a single-byte buffer.
module spart_driver #(
    parameter logic [15:0] DIV_4800   = 16'h028C,
    parameter logic [15:0] DIV_9600   = 16'h0145,
    parameter logic [15:0] DIV_19200  = 16'h00A3,
    parameter logic [15:0] DIV_38400  = 16'h0052,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    br_cfg,
    spart_driver_if.master bus,
    inout  wire  [7:0]    databus,
    output logic          cfg_done,
    output logic [7:0]    echo_cnt
);

    typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RD_RX, WR_TX, GUARD} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  cfg_sel_reg;
    logic        cfg_done_reg;
    logic [7:0]  echo_cnt_reg;

    logic        cs, rw, drive;
    logic [1:0]  addr;
    logic [7:0]  wdata;
    logic        push, pop, set_done, clr_done;
    logic        full, empty;
    logic [7:0]  head;
    logic [1:0]  div_sel;
    logic [15:0] div;

    // CFG_LO uses the live setting because that is the value being latched this cycle.
    assign div_sel = (state_reg == CFG_LO) ? br_cfg : cfg_sel_reg;

    always_comb begin
        div = DIV_9600;
        case (div_sel)
            2'b00: div = DIV_4800;
            2'b01: div = DIV_9600;
            2'b10: div = DIV_19200;
            2'b11: div = DIV_38400;
            default: div = DIV_9600;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cs         = 1'b0;
        rw         = 1'b1;
        addr       = 2'b00;
        wdata      = 8'h00;
        push       = 1'b0;
        pop        = 1'b0;
        set_done   = 1'b0;
        clr_done   = 1'b0;
        case (state_reg)
            CFG_LO: begin
                cs = 1'b1; rw = 1'b0; addr = 2'b10; wdata = div[7:0];
                state_next = CFG_HI;
            end
            CFG_HI: begin
                cs = 1'b1; rw = 1'b0; addr = 2'b11; wdata = div[15:8];
                set_done   = 1'b1;
                state_next = GUARD;
            end
            IDLE: begin
                if (br_cfg != cfg_sel_reg) begin
                    clr_done   = 1'b1;
                    state_next = CFG_LO;
                end else if (bus.rda && !full) begin
                    state_next = RD_RX;
                end else if (!empty && bus.tbr) begin
                    state_next = WR_TX;
                end
            end
            RD_RX: begin
                cs = 1'b1; rw = 1'b1; addr = 2'b00;
                push       = 1'b1;
                state_next = GUARD;
            end
            WR_TX: begin
                cs = 1'b1; rw = 1'b0; addr = 2'b00; wdata = head;
                pop        = 1'b1;
                state_next = GUARD;
            end
            GUARD:   state_next = IDLE;
            default: state_next = CFG_LO;
        endcase
    end

    // Bus outputs are gated by rst so an access in flight drops the instant reset asserts.
    assign bus.iocs   = cs && !rst;
    assign bus.iorw   = rst ? 1'b1 : rw;
    assign bus.ioaddr = rst ? 2'b00 : addr;
    assign drive      = cs && !rw && !rst;
    assign databus    = drive ? wdata : 8'hzz;

    assign cfg_done = cfg_done_reg && !clr_done;
    assign echo_cnt = echo_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= CFG_LO;
            cfg_sel_reg  <= 2'b00;
            cfg_done_reg <= 1'b0;
            echo_cnt_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == CFG_LO)
                cfg_sel_reg <= br_cfg;
            if (clr_done)
                cfg_done_reg <= 1'b0;
            else if (set_done)
                cfg_done_reg <= 1'b1;
            if (pop)
                echo_cnt_reg <= echo_cnt_reg + 8'd1;
        end
    end

`ifdef SPART_DRV_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;

    assign full  = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign empty = (count_reg == '0);
    assign head  = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= databus;
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                count_reg  <= count_reg + 1'b1;
            end else if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                count_reg  <= count_reg - 1'b1;
            end
        end
    end
`else
    logic [7:0] buf_reg;
    logic       valid_reg;

    assign full  = valid_reg;
    assign empty = !valid_reg;
    assign head  = buf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_reg   <= 8'h00;
            valid_reg <= 1'b0;
        end else begin
            if (push) begin
                buf_reg   <= databus;
                valid_reg <= 1'b1;
            end else if (pop) begin
                valid_reg <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: SPART register model on the bus plus a scoreboard of
// received bytes that must come back out on TX in order.
module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] br_cfg = 2'b01;
    wire  [7:0] databus;
    logic       cfg_done;
    logic [7:0] echo_cnt;

    spart_driver_if bus ();

    spart_driver dut (
        .clk      (clk),
        .rst      (rst),
        .br_cfg   (br_cfg),
        .bus      (bus),
        .databus  (databus),
        .cfg_done (cfg_done),
        .echo_cnt (echo_cnt)
    );

    always #10 clk = ~clk;

    // Undriven bus reads as all ones, so a released bus is distinguishable.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pull
        pullup (databus[gi]);
    end

    logic [7:0] rx_front = 8'h00;
    assign databus = (bus.iocs && bus.iorw && bus.ioaddr == 2'b00) ? rx_front : 8'hzz;

    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    int  checks = 0;
    int  errors = 0;
    int  rd_count = 0;
    int  wr_count = 0;
    int  exp_echo = 0;
    int  consec = 0;
    bit  pending_pop = 0;
    bit  prev_iocs = 0;
    bit  prev_xfer = 0;

    task automatic push_rx(input logic [7:0] b);
        rx_q.push_back(b);
        bus.rda  = 1'b1;
        rx_front = rx_q[0];
    endtask

    task automatic flush_rx();
        rx_q.delete();
        bus.rda  = 1'b0;
        rx_front = 8'h00;
    endtask

    // SPART model and TX scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (pending_pop && rx_q.size() != 0) begin
            exp_q.push_back(rx_q.pop_front());
            bus.rda  = (rx_q.size() != 0);
            rx_front = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        end
        pending_pop = 0;
        if (!rst) begin
            if (bus.iocs && prev_iocs && prev_xfer)
                consec++;
            if (bus.iocs && bus.iorw && bus.ioaddr == 2'b00) begin
                rd_count++;
                checks++;
                if (rx_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_rx_read: read with rda low, required no access");
                end else begin
                    pending_pop = 1;
                end
            end
            if (bus.iocs && !bus.iorw && bus.ioaddr == 2'b00) begin
                wr_count++;
                exp_echo++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: wrote %h, required no write", databus);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (databus !== e) begin
                        errors++;
                        $display("FAIL tx_data: got %h, required %h", databus, e);
                    end else
                        $display("tx write %h ok (echo #%0d)", databus, exp_echo);
                end
            end
        end
        prev_xfer = bus.iocs && bus.ioaddr == 2'b00;
        prev_iocs = bus.iocs;
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (bus.iocs !== 1'b0)   begin errors++; $display("FAIL reset_iocs: got %b, required 0", bus.iocs); end
        checks++; if (bus.iorw !== 1'b1)   begin errors++; $display("FAIL reset_iorw: got %b, required 1", bus.iorw); end
        checks++; if (bus.ioaddr !== 2'b00) begin errors++; $display("FAIL reset_ioaddr: got %b, required 00", bus.ioaddr); end
        checks++; if (databus !== 8'hFF)   begin errors++; $display("FAIL reset_databus: got %h, required released (ff)", databus); end
        checks++; if (cfg_done !== 1'b0)   begin errors++; $display("FAIL reset_cfg_done: got %b, required 0", cfg_done); end
        checks++; if (echo_cnt !== 8'd0)   begin errors++; $display("FAIL reset_echo_cnt: got %0d, required 0", echo_cnt); end
        $display("reset state checked");
    endtask

    task automatic check_cfg_write(input string name, input logic [1:0] a, input logic [7:0] d);
        checks++;
        if (bus.iocs !== 1'b1 || bus.iorw !== 1'b0 || bus.ioaddr !== a || databus !== d) begin
            errors++;
            $display("FAIL %s: got iocs=%b iorw=%b addr=%b data=%h, required 1 0 %b %h",
                     name, bus.iocs, bus.iorw, bus.ioaddr, databus, a, d);
        end else
            $display("%s write addr=%b data=%h ok", name, a, d);
    endtask

    task automatic test_config();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); check_cfg_write("cfg_lo", 2'b10, 8'h45);
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL cfg_done_early: got %b, required 0", cfg_done); end
        @(negedge clk); check_cfg_write("cfg_hi", 2'b11, 8'h01);
        @(negedge clk);
        checks++; if (bus.iocs !== 1'b0 || cfg_done !== 1'b1) begin
            errors++; $display("FAIL cfg_guard: got iocs=%b cfg_done=%b, required 0 1", bus.iocs, cfg_done);
        end
    endtask

    task automatic test_echo();
        int w0;
        bus.tbr = 1'b0;
        @(negedge clk);
        w0 = wr_count;
        push_rx(8'hA5);
        @(negedge clk);
        checks++; if (bus.iocs !== 1'b1 || bus.iorw !== 1'b1 || bus.ioaddr !== 2'b00) begin
            errors++; $display("FAIL rx_latency: got iocs=%b iorw=%b addr=%b, required 1 1 00", bus.iocs, bus.iorw, bus.ioaddr);
        end
        @(negedge clk);
        bus.tbr = 1'b1;
        for (int i = 0; i < 10 && wr_count == w0; i++) @(negedge clk);
        checks++; if (wr_count != w0 + 1) begin
            errors++; $display("FAIL echo_timeout: got %0d writes, required 1", wr_count - w0);
        end
        bus.tbr = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (echo_cnt !== 8'd1) begin errors++; $display("FAIL echo_cnt_one: got %0d, required 1", echo_cnt); end
    endtask

    task automatic test_reconfig();
        @(negedge clk);
        br_cfg = 2'b11;
        #1;
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL cfg_done_clear: got %b, required 0", cfg_done); end
        @(negedge clk); check_cfg_write("recfg_lo", 2'b10, 8'h52);
        @(negedge clk); check_cfg_write("recfg_hi", 2'b11, 8'h00);
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL cfg_done_mid: got %b, required 0", cfg_done); end
        @(negedge clk);
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL cfg_done_set: got %b, required 1", cfg_done); end
        repeat (2) @(negedge clk);
        checks++; if (bus.iocs !== 1'b0) begin errors++; $display("FAIL resend_once: got iocs=%b, required 0", bus.iocs); end
    endtask

    task automatic test_buffer();
        int r0, w0, exp_rd;
`ifdef SPART_DRV_FIFO_EN
        exp_rd = 3;
`else
        exp_rd = 1;
`endif
        bus.tbr = 1'b0;
        @(negedge clk);
        r0 = rd_count; w0 = wr_count;
        push_rx(8'h11); push_rx(8'h22); push_rx(8'h33);
        repeat (40) @(negedge clk);
        checks++; if (rd_count - r0 != exp_rd) begin
            errors++; $display("FAIL full_reads: got %0d reads, required %0d", rd_count - r0, exp_rd);
        end else $display("buffer held %0d bytes with tbr low", exp_rd);
        flush_rx();
        bus.tbr = 1'b1;
        for (int i = 0; i < 60 && (wr_count - w0) < exp_rd; i++) @(negedge clk);
        checks++; if (wr_count - w0 != exp_rd || exp_q.size() != 0) begin
            errors++; $display("FAIL drain: got %0d writes, required %0d", wr_count - w0, exp_rd);
        end
        bus.tbr = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (echo_cnt !== 8'(exp_echo)) begin
            errors++; $display("FAIL echo_cnt_drain: got %0d, required %0d", echo_cnt, exp_echo % 256);
        end
    endtask

    task automatic test_wrap();
        int n, c0;
        bit done;
        c0 = consec;
        n = 256 - (exp_echo % 256);
        @(negedge clk);
        for (int i = 0; i < n; i++) push_rx(8'($urandom_range(0, 255)));
        done = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            bus.tbr = ($urandom_range(0, 3) != 0);
            done = (rx_q.size() == 0 && exp_q.size() == 0 && !pending_pop && (exp_echo % 256) == 0);
        end
        bus.tbr = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL wrap_timeout: %0d bytes outstanding, required 0", rx_q.size() + exp_q.size()); end
        repeat (3) @(negedge clk);
        checks++; if (echo_cnt !== 8'd0) begin errors++; $display("FAIL echo_wrap: got %0d, required 0", echo_cnt); end
        else $display("echo_cnt wrapped after %0d bytes", exp_echo);
        checks++; if (consec != c0) begin errors++; $display("FAIL iocs_consecutive: got %0d, required 0", consec - c0); end
    endtask

    task automatic test_rst_mid();
        bit seen;
        @(negedge clk);
        push_rx(8'h5A);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.iocs === 1'b1 && bus.iorw === 1'b1);
        end
        checks++; if (!seen) begin errors++; $display("FAIL rd_wait: no read seen, required one"); end
        rst = 1'b1;
        #1;
        checks++; if (bus.iocs !== 1'b0 || databus !== 8'hFF) begin
            errors++; $display("FAIL rst_mid_bus: got iocs=%b data=%h, required 0 ff", bus.iocs, databus);
        end
        flush_rx();
        exp_q.delete();
        pending_pop = 0;
        exp_echo = 0;
        repeat (2) @(negedge clk);
        checks++; if (echo_cnt !== 8'd0 || cfg_done !== 1'b0) begin
            errors++; $display("FAIL rst_mid_regs: got echo_cnt=%0d cfg_done=%b, required 0 0", echo_cnt, cfg_done);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); check_cfg_write("rst_cfg_lo", 2'b10, 8'h52);
    endtask

    initial begin
        bus.rda = 1'b0;
        bus.tbr = 1'b0;
        test_reset();
        test_config();
        test_echo();
        test_reconfig();
        test_buffer();
        test_wrap();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
